inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 141 ++++++++++++++
 tb/tb_inst_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit with at most one memory request in flight.
//
// Parameters
//   RESET_PC      first fetch address after reset
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   imem_req      one-cycle request pulse to instruction memory
//   imem_addr     fetch address, valid while imem_req=1 (0 otherwise)
//   imem_rvalid   memory response strobe
//   imem_rdata    instruction word, valid with imem_rvalid
//   inst          registered instruction to decode
//   inst_valid    inst and pc_out are valid
//   inst_ready    downstream accepts inst this cycle
//   pc_out        address of the instruction held on inst
//   redirect_en   branch/jump redirect strobe
//   redirect_pc   redirect target address
//   misalign_err  sticky misaligned-redirect flag
//
// Build option: define FETCH_MISALIGN_CHECK_EN to reject misaligned redirect
// targets (sets misalign_err and parks the fetcher until rst). Without it,
// misalign_err is 0 and the low two target bits are forced to zero.
//
// state  | meaning
// S_REQ  | request for pc is on the memory port this cycle
// S_WAIT | request in flight, waiting for imem_rvalid
// S_HOLD | instruction presented on inst, waiting for inst_ready
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc_out,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;        // the next response belongs to a stale request
  logic [31:0] target;
  logic        bad_target;
  logic        parked;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic err_q;

  assign target       = redirect_pc;
  assign bad_target   = redirect_en && (redirect_pc[1:0] != 2'b00);
  assign parked       = err_q;
  assign misalign_err = err_q;

  always_ff @(posedge clk) begin
    if (rst)             err_q <= 1'b0;
    else if (bad_target) err_q <= 1'b1;
  end
`else
  assign target       = redirect_pc & 32'hFFFF_FFFC;
  assign bad_target   = 1'b0;
  assign parked       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // The request is decoded from the registered state so that the very first
  // cycle after reset already carries the RESET_PC request.
  assign imem_req  = !rst && !parked && (state == S_REQ);
  assign imem_addr = imem_req ? pc : 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      inst       <= 32'h0000_0000;
      inst_valid <= 1'b0;
      pc_out     <= 32'h0000_0000;
    end else if (!parked) begin
      if (bad_target) begin
        // misaligned target: ignore the redirect and stop fetching
        state      <= S_REQ;
        inst_valid <= 1'b0;
        drop       <= 1'b0;
      end else begin
        case (state)
          S_REQ: begin
            state <= S_WAIT;
            if (redirect_en) begin
              pc   <= target;
              drop <= 1'b1;
            end
          end
          S_WAIT: begin
            if (redirect_en) begin
              pc <= target;
              if (imem_rvalid) begin
                // the arriving response is the stale one; refetch now
                drop  <= 1'b0;
                state <= S_REQ;
              end else begin
                drop <= 1'b1;
              end
            end else if (imem_rvalid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= S_REQ;
              end else begin
                inst       <= imem_rdata;
                pc_out     <= pc;
                inst_valid <= 1'b1;
                state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (redirect_en) begin
              pc         <= target;
              inst_valid <= 1'b0;
              state      <= S_REQ;
            end else if (inst_ready) begin
              pc         <= pc + 32'd4;
              inst_valid <= 1'b0;
              state      <= S_REQ;
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch; the memory side is driven by
// hand, one response per request, with expected values written inline.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc_out;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .pc_out       (pc_out),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From S_REQ at exp_addr: check the request, return data one cycle later,
  // and stop in S_HOLD with the captured instruction checked.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data);
    chk("req", {31'd0, imem_req}, 32'd1);
    chk("addr", imem_addr, exp_addr);
    tick();
    chk("wait_req", {31'd0, imem_req}, 32'd0);
    chk("wait_valid", {31'd0, inst_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    chk("hold_valid", {31'd0, inst_valid}, 32'd1);
    chk("hold_inst", inst, data);
    chk("hold_pc", pc_out, exp_addr);
  endtask

  initial begin
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);

    // sequential fetch, one instruction every three cycles
    rst = 1'b0;
    #1;
    inst_ready = 1'b1;
    do_fetch(32'h0, 32'h0000_0033);
    tick();
    do_fetch(32'h4, 32'h0000_0033);
    tick();
    do_fetch(32'h8, 32'h0000_0033);
    tick();

    // stall in S_HOLD for five cycles; word with low bits 00 passes through
    inst_ready = 1'b0;
    do_fetch(32'hC, 32'h0000_1234);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, 32'h0000_1234);
      chk("stall_pc", pc_out, 32'hC);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    chk("accept_valid", {31'd0, inst_valid}, 32'd0);

    // redirect in S_WAIT, stale response two cycles later is dropped
    chk("pre_redir_addr", imem_addr, 32'h10);
    tick();
    redirect_en = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_en = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("drop_valid", {31'd0, inst_valid}, 32'd0);
    chk("drop_inst", inst, 32'h0000_1234);
    do_fetch(32'h100, 32'h0000_0013);
    tick();

    // redirect in the same cycle as the response
    chk("same_req_addr", imem_addr, 32'h104);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    tick();
    imem_rvalid = 1'b0; redirect_en = 1'b0;
    chk("same_inst", inst, 32'h0000_0013);
    chk("same_pc_out", pc_out, 32'h100);
    chk("same_valid", {31'd0, inst_valid}, 32'd0);

    // redirect in S_HOLD wins over inst_ready
    do_fetch(32'h200, 32'h0000_0093);
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    chk("hold_redir_valid", {31'd0, inst_valid}, 32'd0);

    // pc wraps past the top of the address space
    do_fetch(32'hFFFF_FFFC, 32'h0000_0013);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);

    // redirect in S_REQ, then again while the drop flag is set
    redirect_en = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_en = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0055;
    tick();
    imem_rvalid = 1'b0;
    chk("dbl_valid", {31'd0, inst_valid}, 32'd0);
    chk("dbl_addr", imem_addr, 32'h400);

    // rvalid outside S_WAIT is ignored
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0077;
    tick();
    imem_rvalid = 1'b0;
    chk("ign_req_valid", {31'd0, inst_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0099;
    tick();
    chk("cap_inst", inst, 32'h0000_0099);
    chk("cap_pc", pc_out, 32'h400);
    inst_ready = 1'b0;
    imem_rdata = 32'h0000_00AA;
    tick();
    imem_rvalid = 1'b0;
    chk("ign_hold_inst", inst, 32'h0000_0099);

    // misaligned redirect target
    redirect_en = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_en = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mis_park_req", {31'd0, imem_req}, 32'd0);
      chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
    end
`else
    chk("mis_err", {31'd0, misalign_err}, 32'd0);
    chk("mis_addr", imem_addr, 32'h100);
`endif

    // mid-operation reset outranks redirect and inst_ready
    rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h800; inst_ready = 1'b1;
    tick();
    chk("rst2_req", {31'd0, imem_req}, 32'd0);
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_inst", inst, 32'h0);
    chk("rst2_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst2_pc_out", pc_out, 32'h0);
    chk("rst2_misalign", {31'd0, misalign_err}, 32'd0);
    rst = 1'b0; redirect_en = 1'b0;
    #1;
    chk("rst2_first_req", {31'd0, imem_req}, 32'd1);
    chk("rst2_first_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
